// File: rtl/fpu_issue_controller.sv
// Issue controller for a FloatingPointUnit: queues decode requests in a FIFO and sends one op at a time to the FPU.
// Each result is sampled after FPU_LATENCY cycles and returned in request order; overflows also set a sticky flag.
module fpu_issue_controller #(
  parameter int DATA_WIDTH  = 32,
  parameter int FPU_LATENCY = 1,
  parameter int REQ_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  input  logic [1:0]            req_op,
  output logic [DATA_WIDTH-1:0] fpu_a,
  output logic [DATA_WIDTH-1:0] fpu_b,
  output logic [1:0]            fpu_operation,
  input  logic [DATA_WIDTH-1:0] fpu_result,
  input  logic                  fpu_overflow,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_overflow,
  output logic                  flag_overflow_sticky,
  input  logic                  flag_clear,
  output logic                  busy
);

  localparam int AW = $clog2(REQ_DEPTH);
  localparam int EW = 2 * DATA_WIDTH + 2;
  localparam int CW = (FPU_LATENCY > 1) ? $clog2(FPU_LATENCY) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(FPU_LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [EW-1:0]         r_mem [REQ_DEPTH];
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic [1:0]            r_state;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_op_a;
  logic [DATA_WIDTH-1:0] r_op_b;
  logic [1:0]            r_op_code;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_result;
  logic                  r_rsp_overflow;
  logic                  r_sticky;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_rsp_hs;
  logic          w_capture;
  logic [EW-1:0] w_head;

  // The extra pointer MSB tells a full FIFO apart from an empty one.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push    = req_valid && !w_full;
  assign w_rsp_hs  = r_rsp_valid && rsp_ready;
  assign w_pop     = !w_empty && ((r_state == S_IDLE) || ((r_state == S_RESP) && w_rsp_hs));
  assign w_capture = (r_state == S_EXEC) && (r_count == LAST_CNT);
  assign w_head    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {req_op, req_b, req_a};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_state        <= S_IDLE;
      r_count        <= '0;
      r_op_a         <= '0;
      r_op_b         <= '0;
      r_op_code      <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_result   <= '0;
      r_rsp_overflow <= 1'b0;
      r_sticky       <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_op_a    <= w_head[DATA_WIDTH-1:0];
        r_op_b    <= w_head[2*DATA_WIDTH-1:DATA_WIDTH];
        r_op_code <= w_head[EW-1:2*DATA_WIDTH];
        r_count   <= '0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_capture) begin
            r_rsp_result   <= fpu_result;
            r_rsp_overflow <= fpu_overflow;
            r_rsp_valid    <= 1'b1;
            r_state        <= S_RESP;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        S_RESP: begin
          if (w_rsp_hs) begin
            r_rsp_valid <= 1'b0;
            r_state     <= w_pop ? S_EXEC : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // A new overflow takes priority over a clear arriving in the same cycle.
      if (w_capture && fpu_overflow) begin
        r_sticky <= 1'b1;
      end else if (flag_clear) begin
        r_sticky <= 1'b0;
      end
    end
  end

  assign req_ready            = !w_full;
  assign fpu_a                = r_op_a;
  assign fpu_b                = r_op_b;
  assign fpu_operation        = r_op_code;
  assign rsp_valid            = r_rsp_valid;
  assign rsp_result           = r_rsp_result;
  assign rsp_overflow         = r_rsp_overflow;
  assign flag_overflow_sticky = r_sticky;
  assign busy                 = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_fpu_issue_controller.sv
// Directed bench for fpu_issue_controller using two instances, one with FPU_LATENCY=1 and one with FPU_LATENCY=3.
// A small FPU stand-in supplies results, and the bench checks them against its own model and scoreboard.
module tb_fpu_issue_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, req_ready, rsp_valid, rsp_ready, rsp_overflow;
  logic        fpu_overflow, sticky, flag_clear, busy;
  logic [31:0] req_a, req_b, fpu_a, fpu_b, fpu_result, rsp_result;
  logic [1:0]  req_op, fpu_op;

  logic        rst3, req_valid3, req_ready3, rsp_valid3, rsp_ready3, rsp_overflow3;
  logic        fpu_overflow3, sticky3, flag_clear3, busy3;
  logic [31:0] req_a3, req_b3, fpu_a3, fpu_b3, fpu_result3, rsp_result3;
  logic [1:0]  req_op3, fpu_op3;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] fmodel(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000 && op == 2'b00) return 32'h4040_0000;
    return (a + b) ^ {op, 30'd0};
  endfunction

  always_comb begin
    fpu_result    = fmodel(fpu_a, fpu_b, fpu_op);
    fpu_overflow  = (fpu_op == 2'b10);
    fpu_result3   = fmodel(fpu_a3, fpu_b3, fpu_op3);
    fpu_overflow3 = (fpu_op3 == 2'b10);
  end

  fpu_issue_controller #(.DATA_WIDTH(32), .FPU_LATENCY(1), .REQ_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_operation(fpu_op),
    .fpu_result(fpu_result), .fpu_overflow(fpu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .flag_overflow_sticky(sticky),
    .flag_clear(flag_clear), .busy(busy)
  );

  fpu_issue_controller #(.DATA_WIDTH(32), .FPU_LATENCY(3), .REQ_DEPTH(4)) dut3 (
    .clk(clk), .rst(rst3), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .req_op(req_op3),
    .fpu_a(fpu_a3), .fpu_b(fpu_b3), .fpu_operation(fpu_op3),
    .fpu_result(fpu_result3), .fpu_overflow(fpu_overflow3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3),
    .rsp_overflow(rsp_overflow3), .flag_overflow_sticky(sticky3),
    .flag_clear(flag_clear3), .busy(busy3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single op on the latency-1 instance, starting from IDLE with the FIFO empty.
  task automatic send_one(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op, input logic clr);
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    check("one_req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("one_e0_rsp_valid", rsp_valid, 0);
    tick();
    check("one_e1_rsp_valid", rsp_valid, 0);
    check("one_e1_fpu_a", fpu_a, a);
    flag_clear = clr;
    tick();
    flag_clear = 1'b0;
    check("one_rsp_valid", rsp_valid, 1);
    check("one_rsp_result", rsp_result, fmodel(a, b, op));
    check("one_rsp_overflow", rsp_overflow, (op == 2'b10) ? 1 : 0);
    $display("txn a=%08h b=%08h op=%0d result=%08h ovf=%0b sticky=%0b", a, b, op, rsp_result, rsp_overflow, sticky);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("one_after_rsp_valid", rsp_valid, 0);
    check("one_after_busy", busy, 0);
  endtask

  initial begin
    int acc, got, sent, seen;
    logic hs_req, hs_rsp, stalled;
    logic [31:0] stall_val, exp_v;

    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0; flag_clear = 1'b0;
    rst3 = 1'b1; req_valid3 = 1'b0; req_a3 = '0; req_b3 = '0; req_op3 = '0; rsp_ready3 = 1'b0; flag_clear3 = 1'b0;
    tick(); tick();
    rst = 1'b0; rst3 = 1'b0;

    // 1: reset in the middle of a stream of overflowing ops
    req_valid = 1'b1; req_a = 32'h11; req_b = 32'h22; req_op = 2'b10;
    tick(); tick(); tick();
    req_valid = 1'b0;
    check("pre_rst_rsp_valid", rsp_valid, 1);
    check("pre_rst_sticky", sticky, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_fpu_a", fpu_a, 0);
    check("rst_fpu_b", fpu_b, 0);
    check("rst_fpu_op", fpu_op, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_overflow", rsp_overflow, 0);
    check("rst_sticky", sticky, 0);
    tick(); tick();
    check("rst_no_rsp_later", rsp_valid, 0);

    // 2: basic latency-1 op
    send_one(32'h3F80_0000, 32'h4000_0000, 2'b00, 1'b0);
    check("basic_fpu_a_hold", fpu_a, 32'h3F80_0000);

    // 3: back-pressure fills the FIFO and the operand registers
    acc = 0;
    req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_a = 32'd100 + 32'(i); req_b = 32'(i); req_op = 2'b01;
      if (req_ready) begin
        acc++;
        exp_q.push_back(fmodel(req_a, req_b, req_op));
      end
      tick();
    end
    req_valid = 1'b0;
    check("full_accepted", 32'(acc), 5);
    check("full_req_ready", req_ready, 0);
    rsp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 60 && got < 5; c++) begin
      if (rsp_valid) begin
        exp_v = exp_q.pop_front();
        check("drain_result", rsp_result, exp_v);
        $display("txn drain #%0d result=%08h", got, rsp_result);
        got++;
      end
      tick();
    end
    rsp_ready = 1'b0;
    check("drain_count", 32'(got), 5);
    check("drain_busy", busy, 0);
    check("drain_rsp_valid", rsp_valid, 0);

    // 4: sticky overflow flag
    check("sticky_start", sticky, 0);
    send_one(32'h7F00_0000, 32'h7F00_0000, 2'b10, 1'b0);
    check("sticky_set", sticky, 1);
    send_one(32'h1, 32'h2, 2'b00, 1'b0);
    check("sticky_hold_clean", sticky, 1);
    send_one(32'h7F7F_0000, 32'h3, 2'b10, 1'b1);
    check("sticky_set_wins", sticky, 1);
    flag_clear = 1'b1;
    tick();
    flag_clear = 1'b0;
    check("sticky_cleared", sticky, 0);

    // 5: random traffic with random response back-pressure
    exp_q.delete();
    sent = 0; got = 0; stalled = 1'b0; stall_val = '0;
    for (int c = 0; c < 3000 && got < 50; c++) begin
      req_valid = (sent < 50) && ($urandom_range(0, 1) == 1);
      req_a = $urandom; req_b = $urandom; req_op = 2'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 1) == 1);
      if (stalled) begin
        check("stall_valid", rsp_valid, 1);
        check("stall_result", rsp_result, stall_val);
      end
      hs_req = req_valid && req_ready;
      hs_rsp = rsp_valid && rsp_ready;
      if (hs_req) begin
        exp_q.push_back(fmodel(req_a, req_b, req_op));
        sent++;
      end
      if (hs_rsp) begin
        check("sb_not_extra", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          exp_v = exp_q.pop_front();
          check("sb_result", rsp_result, exp_v);
        end
        got++;
      end
      stalled = rsp_valid && !rsp_ready;
      stall_val = rsp_result;
      tick();
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    check("sb_got", 32'(got), 50);
    check("sb_left", 32'(exp_q.size()), 0);
    $display("txn random ops sent=%0d received=%0d", sent, got);

    // 6: latency-3 instance, one normal op, then a reset while the op is executing
    req_valid3 = 1'b1; req_a3 = 32'h0000_1234; req_b3 = 32'h0000_0010; req_op3 = 2'b11;
    tick();
    req_valid3 = 1'b0;
    tick();
    check("l3_e1_valid", rsp_valid3, 0);
    tick();
    check("l3_e2_valid", rsp_valid3, 0);
    tick();
    check("l3_e3_valid", rsp_valid3, 0);
    check("l3_fpu_a_stable", fpu_a3, 32'h0000_1234);
    tick();
    check("l3_e4_valid", rsp_valid3, 1);
    check("l3_result", rsp_result3, fmodel(32'h0000_1234, 32'h0000_0010, 2'b11));
    rsp_ready3 = 1'b1;
    tick();
    rsp_ready3 = 1'b0;
    check("l3_done_busy", busy3, 0);

    req_valid3 = 1'b1; req_a3 = 32'hABCD; req_b3 = 32'h1; req_op3 = 2'b00;
    tick();
    req_valid3 = 1'b0;
    tick(); tick();
    check("l3_inflight_busy", busy3, 1);
    rst3 = 1'b1;
    rsp_ready3 = 1'b1;
    tick();
    rst3 = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (rsp_valid3) seen++;
      tick();
    end
    check("l3_rst_no_rsp", 32'(seen), 0);
    check("l3_rst_busy", busy3, 0);
    check("l3_rst_req_ready", req_ready3, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
